output_controller: RTL and testbench

- Output-side counterpart of the Winograd F(4x4,3x3) input controller.
- Accepts 6x6 accumulated element-wise product tiles M from the two PE array lanes and computes the inverse transform Y = A^T M A (4x4).
- Scales and saturates each result, then queues it.
- Writes each 4x4 result tile back to memory over a valid/ready write port.
- Sits between the PE arrays and output memory, mirroring the input path's two-lane structure.

---
 rtl/winograd_pkg.sv | 35 +++
 rtl/winograd_at_transform.sv | 118 +++++++++++
 rtl/output_controller.sv | 118 +++++++++++
 tb/tb_output_controller.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/winograd_pkg.sv
// rtl/winograd_pkg.sv - Winograd F(4x4,3x3) inverse-transform constants, coefficient table and tile types
package winograd_pkg;

    localparam int TILE_IN   = 6;
    localparam int TILE_OUT  = 4;
    localparam int ACC_W_DEF = 32;
    localparam int OUT_W_DEF = 16;

    // A^T coefficient: magnitude is 1 << sh, nz=0 marks a zero coefficient
    typedef struct packed {
        logic       nz;
        logic       neg;
        logic [1:0] sh;
    } at_coef_t;

    localparam at_coef_t C_Z  = '{1'b0, 1'b0, 2'd0};
    localparam at_coef_t C_P1 = '{1'b1, 1'b0, 2'd0};
    localparam at_coef_t C_M1 = '{1'b1, 1'b1, 2'd0};
    localparam at_coef_t C_P2 = '{1'b1, 1'b0, 2'd1};
    localparam at_coef_t C_M2 = '{1'b1, 1'b1, 2'd1};
    localparam at_coef_t C_P4 = '{1'b1, 1'b0, 2'd2};
    localparam at_coef_t C_P8 = '{1'b1, 1'b0, 2'd3};
    localparam at_coef_t C_M8 = '{1'b1, 1'b1, 2'd3};

    localparam at_coef_t AT_COEF [TILE_OUT][TILE_IN] = '{
        '{C_P1, C_P1, C_P1, C_P1, C_P1, C_Z },
        '{C_Z,  C_P1, C_M1, C_P2, C_M2, C_Z },
        '{C_Z,  C_P1, C_P1, C_P4, C_P4, C_Z },
        '{C_Z,  C_P1, C_M1, C_P8, C_M8, C_P1}
    };

    typedef logic signed [TILE_IN-1:0][TILE_IN-1:0][ACC_W_DEF-1:0] acc_tile_t;
    typedef logic [TILE_OUT*TILE_OUT*OUT_W_DEF-1:0]                 out_tile_t;

endpackage

// File: rtl/winograd_at_transform.sv
// rtl/winograd_at_transform.sv - one lane of the two-stage Y = A^T M A datapath with scale/saturate
// Optional macro: OUTPUT_TRANSFORM_RELU_EN clamps negative results to zero before saturation.
module winograd_at_transform
    import winograd_pkg::*;
#(
    parameter int ACC_W = 32,
    parameter int OUT_W = 16,
    parameter int SHIFT = 0
) (
    input  logic                                             clk,
    input  logic                                             reset,
    input  logic                                             in_valid,
    input  logic [7:0]                                       in_addr,
    input  logic signed [TILE_IN-1:0][TILE_IN-1:0][ACC_W-1:0] in_tile,
    output logic                                             s1_valid,
    output logic                                             out_valid,
    output logic [7:0]                                       out_addr,
    output logic [TILE_OUT*TILE_OUT*OUT_W-1:0]               out_data
);

    localparam int TW    = ACC_W + 5;
    localparam int YW    = ACC_W + 10;
    localparam int EXT_T = TW - ACC_W;
    localparam int EXT_Y = YW - TW;
    localparam logic signed [YW-1:0] SAT_MAX = {{(YW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [YW-1:0] SAT_MIN = ~SAT_MAX;

    function automatic logic signed [TW-1:0] term_t(input logic signed [TW-1:0] v, input at_coef_t c);
        logic signed [TW-1:0] s;
        s = v <<< c.sh;
        if (!c.nz)
            s = '0;
        else if (c.neg)
            s = -s;
        return s;
    endfunction

    function automatic logic signed [YW-1:0] term_y(input logic signed [YW-1:0] v, input at_coef_t c);
        logic signed [YW-1:0] s;
        s = v <<< c.sh;
        if (!c.nz)
            s = '0;
        else if (c.neg)
            s = -s;
        return s;
    endfunction

    logic signed [TW-1:0]              t_comb [TILE_OUT][TILE_IN];
    logic signed [TW-1:0]              t_q    [TILE_OUT][TILE_IN];
    logic [7:0]                        s1_addr;
    logic [TILE_OUT*TILE_OUT*OUT_W-1:0] y_comb;

    // Stage 1: T = A^T M, column by column
    always_comb begin : stage1
        logic signed [TW-1:0] acc;
        logic signed [TW-1:0] ext;
        acc = '0;
        ext = '0;
        for (int i = 0; i < TILE_OUT; i++) begin
            for (int c = 0; c < TILE_IN; c++) begin
                acc = '0;
                for (int r = 0; r < TILE_IN; r++) begin
                    ext = {{EXT_T{in_tile[r][c][ACC_W-1]}}, in_tile[r][c]};
                    acc = acc + term_t(ext, AT_COEF[i][r]);
                end
                t_comb[i][c] = acc;
            end
        end
    end

    // Stage 2: Y = T A, then floor shift, optional clamp, saturate and pack row-major MSB first
    always_comb begin : stage2
        logic signed [YW-1:0] acc;
        logic signed [YW-1:0] clip;
        acc    = '0;
        clip   = '0;
        y_comb = '0;
        for (int i = 0; i < TILE_OUT; i++) begin
            for (int j = 0; j < TILE_OUT; j++) begin
                acc = '0;
                for (int c = 0; c < TILE_IN; c++)
                    acc = acc + term_y({{EXT_Y{t_q[i][c][TW-1]}}, t_q[i][c]}, AT_COEF[j][c]);
                clip = acc >>> SHIFT;
`ifdef OUTPUT_TRANSFORM_RELU_EN
                if (clip < 0)
                    clip = '0;
`endif
                if (clip > SAT_MAX)
                    clip = SAT_MAX;
                else if (clip < SAT_MIN)
                    clip = SAT_MIN;
                y_comb[(TILE_OUT*TILE_OUT-1-(TILE_OUT*i+j))*OUT_W +: OUT_W] = clip[OUT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_addr   <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
        end else begin
            s1_valid  <= in_valid;
            s1_addr   <= in_addr;
            out_valid <= s1_valid;
            out_addr  <= s1_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid)
            t_q <= t_comb;
        if (s1_valid)
            out_data <= y_comb;
    end

endmodule

// File: rtl/output_controller.sv
// rtl/output_controller.sv - two-lane Winograd inverse transform, result FIFO and memory write port
// Optional macro: OUTPUT_TRANSFORM_RELU_EN (passed through to the lane datapaths).
module output_controller
    import winograd_pkg::*;
#(
    parameter int ACC_W = 32,
    parameter int OUT_W = 16,
    parameter int SHIFT = 0,
    parameter int DEPTH = 8
) (
    input  logic                                             clk,
    input  logic                                             reset,
    input  logic signed [TILE_IN-1:0][TILE_IN-1:0][ACC_W-1:0] pe_tile_i_1,
    input  logic signed [TILE_IN-1:0][TILE_IN-1:0][ACC_W-1:0] pe_tile_i_2,
    input  logic [7:0]                                       pe_addr_i_1,
    input  logic [7:0]                                       pe_addr_i_2,
    input  logic                                             pe_valid_i_1,
    input  logic                                             pe_valid_i_2,
    output logic                                             pe_ready_o,
    input  logic [7:0]                                       out_base_i,
    output logic [7:0]                                       wr_addr_o,
    output logic [TILE_OUT*TILE_OUT*OUT_W-1:0]               wr_data_o,
    output logic                                             wr_valid_o,
    input  logic                                             wr_ready_i,
    output logic                                             busy_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = TILE_OUT * TILE_OUT * OUT_W;

    logic          ready_en;
    logic          credit_ok;
    logic          acc_1, acc_2;
    logic [7:0]    addr_1, addr_2;
    logic          s1_valid_1, s1_valid_2;
    logic          push_1, push_2, pop;
    logic [7:0]    y_addr_1, y_addr_2;
    logic [DW-1:0] y_data_1, y_data_2;
    logic [2:0]    inflight;

    logic [DW-1:0] fifo_data [DEPTH];
    logic [7:0]    fifo_addr [DEPTH];
    logic [PW-1:0] wp, rp, wp_l2;
    logic [CW-1:0] count;

    assign acc_1  = pe_valid_i_1 && pe_ready_o;
    assign acc_2  = pe_valid_i_2 && pe_ready_o;
    assign addr_1 = pe_addr_i_1 + out_base_i;
    assign addr_2 = pe_addr_i_2 + out_base_i;

    winograd_at_transform #(.ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_lane_1 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (acc_1),
        .in_addr   (addr_1),
        .in_tile   (pe_tile_i_1),
        .s1_valid  (s1_valid_1),
        .out_valid (push_1),
        .out_addr  (y_addr_1),
        .out_data  (y_data_1)
    );

    winograd_at_transform #(.ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_lane_2 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (acc_2),
        .in_addr   (addr_2),
        .in_tile   (pe_tile_i_2),
        .s1_valid  (s1_valid_2),
        .out_valid (push_2),
        .out_addr  (y_addr_2),
        .out_data  (y_data_2)
    );

    // Every tile in the pipeline holds a reserved FIFO slot, so a dual accept needs two spare slots
    assign inflight  = 3'(s1_valid_1) + 3'(s1_valid_2) + 3'(push_1) + 3'(push_2);
    assign credit_ok = (32'(count) + 32'(inflight) + 32'd2) <= 32'(DEPTH);
    assign pe_ready_o = ready_en && credit_ok;

    assign wr_valid_o = (count != '0);
    assign wr_addr_o  = wr_valid_o ? fifo_addr[rp] : '0;
    assign wr_data_o  = wr_valid_o ? fifo_data[rp] : '0;
    assign pop        = wr_valid_o && wr_ready_i;
    assign busy_o     = s1_valid_1 || s1_valid_2 || push_1 || push_2 || wr_valid_o;

    // Lane 2 lands behind lane 1 when both complete together
    assign wp_l2 = push_1 ? wp + PW'(1) : wp;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_en <= 1'b0;
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
        end else begin
            ready_en <= 1'b1;
            wp       <= wp + PW'(push_1) + PW'(push_2);
            rp       <= rp + PW'(pop);
            count    <= count + CW'(push_1) + CW'(push_2) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push_1) begin
            fifo_data[wp] <= y_data_1;
            fifo_addr[wp] <= y_addr_1;
        end
        if (push_2) begin
            fifo_data[wp_l2] <= y_data_2;
            fifo_addr[wp_l2] <= y_addr_2;
        end
    end

    assert property (@(posedge clk) disable iff (reset)
        (32'(count) + 32'(push_1) + 32'(push_2)) <= (32'(DEPTH) + 32'(pop)));

endmodule

// File: tb/tb_output_controller.sv
// tb/tb_output_controller.sv - scoreboard bench for output_controller
module tb_output_controller;
    import winograd_pkg::*;

    localparam int ACC_W = 32;
    localparam int OUT_W = 16;
    localparam int SHIFT = 0;
    localparam int DEPTH = 8;
    localparam int AT [4][6] = '{'{1, 1, 1, 1, 1, 0}, '{0, 1, -1, 2, -2, 0},
                                 '{0, 1, 1, 4, 4, 0}, '{0, 1, -1, 8, -8, 1}};

    typedef struct {
        logic [7:0]   a;
        logic [255:0] d;
    } exp_t;

    logic         clk, reset;
    acc_tile_t    pe_tile_i_1, pe_tile_i_2;
    logic [7:0]   pe_addr_i_1, pe_addr_i_2, out_base_i, wr_addr_o;
    logic         pe_valid_i_1, pe_valid_i_2, pe_ready_o, wr_valid_o, wr_ready_i, busy_o;
    logic [255:0] wr_data_o;
    logic         toggle_en;

    int   n_checks, n_errors;
    exp_t q[$];

    output_controller #(.ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .pe_tile_i_1(pe_tile_i_1), .pe_tile_i_2(pe_tile_i_2),
        .pe_addr_i_1(pe_addr_i_1), .pe_addr_i_2(pe_addr_i_2),
        .pe_valid_i_1(pe_valid_i_1), .pe_valid_i_2(pe_valid_i_2),
        .pe_ready_o(pe_ready_o), .out_base_i(out_base_i),
        .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .wr_valid_o(wr_valid_o),
        .wr_ready_i(wr_ready_i), .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] model(input acc_tile_t m);
        longint       t [4][6];
        longint       y;
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 4; i++)
            for (int c = 0; c < 6; c++) begin
                t[i][c] = 0;
                for (int k = 0; k < 6; k++)
                    t[i][c] += longint'(AT[i][k]) * longint'($signed(m[k][c]));
            end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                y = 0;
                for (int c = 0; c < 6; c++)
                    y += t[i][c] * longint'(AT[j][c]);
                y = y >>> SHIFT;
`ifdef OUTPUT_TRANSFORM_RELU_EN
                if (y < 0) y = 0;
`endif
                if (y > 32767) y = 32767;
                if (y < -32768) y = -32768;
                r[(15-(4*i+j))*16 +: 16] = y[15:0];
            end
        return r;
    endfunction

    function automatic acc_tile_t rand_tile(input int amp);
        acc_tile_t t;
        int        v;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++) begin
                v = int'($urandom_range(2 * amp, 0)) - amp;
                t[r][c] = v;
            end
        return t;
    endfunction

    // Called just after a rising edge; returns after the edge that sampled the request
    task automatic send(input acc_tile_t m1, input logic v1, input logic [7:0] a1,
                        input acc_tile_t m2, input logic v2, input logic [7:0] a2,
                        output logic acc);
        pe_tile_i_1 = m1; pe_valid_i_1 = v1; pe_addr_i_1 = a1;
        pe_tile_i_2 = m2; pe_valid_i_2 = v2; pe_addr_i_2 = a2;
        @(negedge clk);
        acc = pe_ready_o;
        if (acc && v1) q.push_back('{a: 8'(a1 + out_base_i), d: model(m1)});
        if (acc && v2) q.push_back('{a: 8'(a2 + out_base_i), d: model(m2)});
        @(posedge clk); #1;
        pe_valid_i_1 = 1'b0;
        pe_valid_i_2 = 1'b0;
    endtask

    task automatic send_one(input acc_tile_t m, input logic [7:0] a);
        logic acc;
        int   k;
        k = 0;
        acc = 1'b0;
        while (!acc && k < 50) begin
            send(m, 1'b1, a, '0, 1'b0, 8'h00, acc);
            k++;
        end
        if (!acc) check("send_timeout", 256'(pe_ready_o), 256'(1));
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_valid();
        int k;
        k = 0;
        @(negedge clk);
        while (!wr_valid_o && k < 20) begin @(negedge clk); k++; end
        if (!wr_valid_o) check("wait_valid_timeout", 256'(wr_valid_o), 256'(1));
    endtask

    task automatic drain(input int bound);
        int k;
        k = 0;
        while ((q.size() != 0 || busy_o) && k < bound) begin @(posedge clk); #1; k++; end
        check("drain_empty", 256'(q.size()), 256'(0));
        check("drain_idle", 256'(busy_o), 256'(0));
    endtask

    // Write-port scoreboard: the head entry must be presented every cycle wr_valid_o is high
    initial forever begin
        @(negedge clk);
        if (!reset && wr_valid_o) begin
            if (q.size() == 0) begin
                check("unexpected_write", 256'(wr_valid_o), 256'(0));
            end else begin
                check("wr_addr", 256'(wr_addr_o), 256'(q[0].a));
                check("wr_data", wr_data_o, q[0].d);
                if (wr_ready_i) q.delete(0);
            end
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (toggle_en) wr_ready_i = !wr_ready_i;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        acc_tile_t m, m2;
        logic      acc;
        int        lat, n_acc;

        n_checks = 0; n_errors = 0; toggle_en = 1'b0;
        reset = 1'b1; wr_ready_i = 1'b0; out_base_i = 8'h00;
        pe_tile_i_1 = '0; pe_tile_i_2 = '0; pe_addr_i_1 = '0; pe_addr_i_2 = '0;
        pe_valid_i_1 = 1'b0; pe_valid_i_2 = 1'b0;
        idle(2);
        check("rst_wr_valid", 256'(wr_valid_o), 256'(0));
        check("rst_pe_ready", 256'(pe_ready_o), 256'(0));
        check("rst_busy", 256'(busy_o), 256'(0));
        check("rst_wr_addr", 256'(wr_addr_o), 256'(0));
        check("rst_wr_data", wr_data_o, 256'(0));
        reset = 1'b0;
        #1 check("ready_before_edge", 256'(pe_ready_o), 256'(0));
        @(posedge clk); #1;
        check("ready_after_edge", 256'(pe_ready_o), 256'(1));

        // All-ones tile, latency and explicit rows
        wr_ready_i = 1'b1;
        for (int r = 0; r < 6; r++) for (int c = 0; c < 6; c++) m[r][c] = 32'sd1;
        send(m, 1'b1, 8'h10, '0, 1'b0, 8'h00, acc);
        check("accept_ones", 256'(acc), 256'(1));
        lat = 1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (wr_valid_o) break;
            @(posedge clk); lat++;
        end
        check("latency", 256'(lat), 256'(3));
        check("ones_row0", 256'(wr_data_o[255-:64]), 256'({16'd25, 16'd0, 16'd50, 16'd5}));
        check("ones_row1", 256'(wr_data_o[191-:64]), 256'(0));
        check("ones_row2", 256'(wr_data_o[127-:64]), 256'({16'd50, 16'd0, 16'd100, 16'd10}));
        check("ones_row3", 256'(wr_data_o[63-:64]), 256'({16'd5, 16'd0, 16'd10, 16'd1}));
        idle(3);

        // Impulses
        m = '0; m[5][5] = 32'sd7;
        send_one(m, 8'h20);
        wait_valid();
        check("imp_y33", 256'(wr_data_o[15:0]), 256'(16'd7));
        check("imp_rest", 256'(wr_data_o[255:16]), 256'(0));
        @(posedge clk); #1; idle(3);
        m = '0; m[3][3] = -32'sd1000;
        send_one(m, 8'h21);
        wait_valid();
`ifdef OUTPUT_TRANSFORM_RELU_EN
        check("neg_y00", 256'(wr_data_o[255-:16]), 256'(16'h0000));
        check("neg_y33", 256'(wr_data_o[15:0]), 256'(16'h0000));
`else
        check("neg_y00", 256'(wr_data_o[255-:16]), 256'(16'hFC18));
        check("neg_y33", 256'(wr_data_o[15:0]), 256'(16'h8000));
`endif
        @(posedge clk); #1;
        drain(20);

        // Lane 2 one cycle behind lane 1, then dual push
        send(rand_tile(20), 1'b1, 8'h30, '0, 1'b0, 8'h00, acc);
        send('0, 1'b0, 8'h00, rand_tile(20), 1'b1, 8'h31, acc);
        send(rand_tile(20), 1'b1, 8'h32, rand_tile(20), 1'b1, 8'h33, acc);
        drain(30);

        // Fill with both lanes every cycle while writes are blocked
        wr_ready_i = 1'b0; out_base_i = 8'hFE; n_acc = 0;
        for (int k = 0; k < 8; k++) begin
            send(rand_tile(30), 1'b1, 8'h03, rand_tile(30), 1'b1, 8'h09, acc);
            if (acc) n_acc += 2;
            if (k == 4) check("ready_drop", 256'(acc), 256'(0));
        end
        check("fill_count", 256'(n_acc), 256'(DEPTH));
        check("full_ready", 256'(pe_ready_o), 256'(0));
        check("full_valid", 256'(wr_valid_o), 256'(1));
        check("full_head_addr", 256'(wr_addr_o), 256'(8'h01));
        wr_ready_i = 1'b1;
        drain(40);

        // Toggling write-ready with random lane valids
        out_base_i = 8'h20; toggle_en = 1'b1;
        for (int k = 0; k < 12; k++)
            send(rand_tile(1000), 1'($urandom_range(1, 0)), 8'(2 * k),
                 rand_tile(1000), 1'($urandom_range(1, 0)), 8'(2 * k + 1), acc);
        drain(100);
        toggle_en = 1'b0; #1; wr_ready_i = 1'b0;

        // Reset with three tiles queued and two in flight
        out_base_i = 8'h00;
        send(rand_tile(20), 1'b1, 8'h40, rand_tile(20), 1'b1, 8'h41, acc);
        send(rand_tile(20), 1'b1, 8'h42, '0, 1'b0, 8'h00, acc);
        idle(3);
        send(rand_tile(20), 1'b1, 8'h43, rand_tile(20), 1'b1, 8'h44, acc);
        reset = 1'b1;
        #1;
        check("mid_rst_wr_valid", 256'(wr_valid_o), 256'(0));
        check("mid_rst_wr_addr", 256'(wr_addr_o), 256'(0));
        check("mid_rst_wr_data", wr_data_o, 256'(0));
        check("mid_rst_busy", 256'(busy_o), 256'(0));
        check("mid_rst_ready", 256'(pe_ready_o), 256'(0));
        q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        idle(1);
        wr_ready_i = 1'b1;
        m2 = rand_tile(50);
        send_one(m2, 8'h55);
        drain(20);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
